// File: rtl/prio_encoder_mt.sv
// prio_encoder_mt: arbitrates N_SRC memory readers onto one output stream.
// A registered one-hot select grants one reader at a time (lowest index
// wins, grant is sticky until that reader runs dry). Returned words land in
// a 4-entry skid FIFO whose head drives dout/dout_src/dout_valid. The select
// is withheld once the FIFO is half full, so words already requested still
// fit while the downstream stalls.
module prio_encoder_mt #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 36,
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    init,
    input  logic                    setup,
    input  logic [N_SRC-1:0]        has_dat,
    input  logic [N_SRC-1:0]        mem_valid,
    input  logic [N_SRC*DATA_W-1:0] mem_dat,
    input  logic                    stall,
    output logic [N_SRC-1:0]        sel,
    output logic [DATA_W-1:0]       dout,
    output logic [SRC_W-1:0]        dout_src,
    output logic                    dout_valid,
    output logic                    done,
    output logic                    collide
);

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int OCC_W = 3;
    localparam logic [OCC_W-1:0] OCC_THROTTLE = OCC_W'(DEPTH - 2);
    localparam logic [OCC_W-1:0] OCC_FULL     = OCC_W'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ARB   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Isolate the lowest set bit of a request vector.
    function automatic logic [N_SRC-1:0] lowest_onehot(input logic [N_SRC-1:0] v);
        return v & (~v + N_SRC'(1));
    endfunction

    // True when more than one bit of the vector is set.
    function automatic logic multi_hot(input logic [N_SRC-1:0] v);
        return |(v & (v - N_SRC'(1)));
    endfunction

    state_t              state_q, state_d;
    logic [N_SRC-1:0]    sel_q, sel_d;
    logic                quiet_q, quiet_d;
    logic                done_q, done_d;
    logic                collide_q, collide_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [SRC_W-1:0]    fifo_src_q [DEPTH];
    logic [DATA_W-1:0]   fifo_dat_q [DEPTH];
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [SRC_W-1:0]    dout_src_q, dout_src_d;
    logic                dout_valid_q, dout_valid_d;

    logic [N_SRC-1:0]    push_oh_s;
    logic [SRC_W-1:0]    push_src_s;
    logic [DATA_W-1:0]   push_dat_s;
    logic                multi_s;
    logic                push_s;
    logic                pop_s;
    logic                fifo_empty_s;
    logic                fifo_full_s;
    logic [OCC_W-1:0]    remain_s;

    // Pick the lowest-index returning word and decide push/pop for this cycle.
    always_comb begin
        push_oh_s  = lowest_onehot(mem_valid);
        multi_s    = multi_hot(mem_valid);
        push_src_s = '0;
        push_dat_s = '0;
        for (int i = 0; i < N_SRC; i++) begin
            push_src_s = push_src_s | (push_oh_s[i] ? SRC_W'(i) : '0);
            push_dat_s = push_dat_s | (push_oh_s[i] ? mem_dat[i*DATA_W +: DATA_W] : '0);
        end
        fifo_empty_s = (occ_q == '0);
        fifo_full_s  = (occ_q == OCC_FULL);
        // init discards everything, including words arriving in that cycle
        pop_s    = !fifo_empty_s && !stall && !init;
        push_s   = (|mem_valid) && (!fifo_full_s || pop_s) && !init;
        remain_s = occ_q - (pop_s ? OCC_W'(1) : OCC_W'(0));
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (init) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
            rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Next FIFO head: a stored entry if one remains after the pop, otherwise
    // the word being pushed now (gives 1-cycle latency through an empty FIFO).
    always_comb begin
        dout_valid_d = 1'b0;
        dout_d       = '0;
        dout_src_d   = '0;
        if (init) begin
            dout_valid_d = 1'b0;
        end else if (remain_s != '0) begin
            dout_valid_d = 1'b1;
            dout_d       = fifo_dat_q[rd_ptr_d];
            dout_src_d   = fifo_src_q[rd_ptr_d];
        end else if (push_s) begin
            dout_valid_d = 1'b1;
            dout_d       = push_dat_s;
            dout_src_d   = push_src_s;
        end else begin
            dout_valid_d = 1'b0;
        end
    end

    // Crossing state machine and reader select.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        quiet_d = 1'b0;
        if (init) begin
            state_d = ST_SETUP;
            sel_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sel_d = '0;
                end
                ST_SETUP: begin
                    sel_d   = '0;
                    state_d = setup ? ST_SETUP : ST_ARB;
                end
                ST_ARB: begin
                    if ((has_dat == '0) && (sel_q == '0)) begin
                        state_d = ST_FLUSH;
                        sel_d   = '0;
                    end else if (occ_q >= OCC_THROTTLE) begin
                        // words already requested still need room
                        sel_d = '0;
                    end else if ((has_dat & sel_q) != '0) begin
                        sel_d = sel_q;
                    end else begin
                        sel_d = lowest_onehot(has_dat);
                    end
                end
                ST_FLUSH: begin
                    sel_d = '0;
                    if (|has_dat) begin
                        state_d = ST_ARB;
                    end else if ((mem_valid == '0) && fifo_empty_s) begin
                        state_d = quiet_q ? ST_DONE : ST_FLUSH;
                        quiet_d = 1'b1;
                    end else begin
                        quiet_d = 1'b0;
                    end
                end
                ST_DONE: begin
                    sel_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                end
            endcase
        end
        done_d    = (state_d == ST_DONE);
        collide_d = init ? 1'b0 : (collide_q | multi_s);
    end

    // Control, status and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            quiet_q      <= 1'b0;
            done_q       <= 1'b0;
            collide_q    <= 1'b0;
            occ_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            dout_q       <= '0;
            dout_src_q   <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            quiet_q      <= quiet_d;
            done_q       <= done_d;
            collide_q    <= collide_d;
            occ_q        <= occ_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            dout_q       <= dout_d;
            dout_src_q   <= dout_src_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Skid FIFO storage of {source index, word}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_src_q[i] <= '0;
                fifo_dat_q[i] <= '0;
            end
        end else if (push_s) begin
            fifo_src_q[wr_ptr_q] <= push_src_s;
            fifo_dat_q[wr_ptr_q] <= push_dat_s;
        end
    end

    assign sel        = sel_q;
    assign dout       = dout_q;
    assign dout_src   = dout_src_q;
    assign dout_valid = dout_valid_q;
    assign done       = done_q;
    assign collide    = collide_q;

endmodule

// File: tb/tb_prio_encoder_mt.sv
// Bench for prio_encoder_mt: behavioural readers (one registered cycle from
// select to mem_valid), directed crossings, and a scoreboard queue popped by
// an independent output monitor.
module tb_prio_encoder_mt;

    localparam int N = 4;
    localparam int W = 36;

    logic           clk = 1'b0;
    logic           rst_n, init, setup, stall;
    logic [N-1:0]   has_dat, mem_valid, sel;
    logic [N*W-1:0] mem_dat;
    logic [W-1:0]   dout;
    logic [1:0]     dout_src;
    logic           dout_valid, done, collide;

    prio_encoder_mt #(.N_SRC(N), .DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .init(init), .setup(setup),
        .has_dat(has_dat), .mem_valid(mem_valid), .mem_dat(mem_dat),
        .stall(stall), .sel(sel), .dout(dout), .dout_src(dout_src),
        .dout_valid(dout_valid), .done(done), .collide(collide)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   src;
        logic [W-1:0] dat;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    // reader model state
    int           cnt [N];
    int           idx [N];
    logic [N-1:0] mv_r;
    logic [W-1:0] dat_r [N];
    logic         ld;
    int           ld_cnt [N];
    logic [N-1:0] ld_mask;
    logic [N-1:0] mv_force;
    logic [W-1:0] dat_force [N];

    function automatic logic [W-1:0] mk_word(input int s, input int k);
        logic [7:0]  s8;
        logic [23:0] k24;
        s8  = s[7:0];
        k24 = k[23:0];
        return {4'hA, s8, k24};
    endfunction

    // Readers: a granted reader with items left returns one word next cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_r <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i]   <= 0;
                idx[i]   <= 0;
                dat_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (init) begin
                    mv_r[i] <= 1'b0;
                    idx[i]  <= 0;
                    cnt[i]  <= (ld && ld_mask[i]) ? ld_cnt[i] : 0;
                end else begin
                    mv_r[i] <= 1'b0;
                    if (sel[i] && cnt[i] > 0) begin
                        mv_r[i]  <= 1'b1;
                        dat_r[i] <= mk_word(i, idx[i]);
                        idx[i]   <= idx[i] + 1;
                        cnt[i]   <= cnt[i] - 1;
                    end
                    if (ld && ld_mask[i]) cnt[i] <= ld_cnt[i];
                end
            end
        end
    end

    always_comb begin
        mem_valid = mv_r | mv_force;
        mem_dat   = '0;
        has_dat   = '0;
        for (int i = 0; i < N; i++) begin
            has_dat[i]          = (cnt[i] != 0);
            mem_dat[i*W +: W]   = mv_force[i] ? dat_force[i] : dat_r[i];
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_w(input int s, input int k);
        exp_t e;
        e.src = s[1:0];
        e.dat = mk_word(s, k);
        q.push_back(e);
    endtask

    task automatic start_crossing(input int c0, input int c1, input int c2, input int c3);
        ld_cnt[0] = c0; ld_cnt[1] = c1; ld_cnt[2] = c2; ld_cnt[3] = c3;
        ld_mask = 4'b1111;
        ld = 1'b1; init = 1'b1; setup = 1'b1;
        tick(1);
        ld = 1'b0; init = 1'b0;
        tick(2);
        setup = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string nm);
        int k;
        k = 0;
        while (done !== 1'b1 && k < bound) begin
            tick(1);
            k++;
        end
        check(nm, done, 1);
    endtask

    // Monitor: every accepted output word is compared with the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (dout_valid === 1'b1 && stall === 1'b0) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got src=%0d dat=0x%0h, expected no word", dout_src, dout);
                end else begin
                    mon_e = q.pop_front();
                    check("sb_src", dout_src, mon_e.src);
                    check("sb_dat", dout, mon_e.dat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b1; init = 1'b0; setup = 1'b0; stall = 1'b0; ld = 1'b0;
        ld_mask = '0; mv_force = '0;
        for (int i = 0; i < N; i++) begin
            ld_cnt[i]    = 0;
            dat_force[i] = '0;
        end
        #2 rst_n = 1'b0;
        tick(2);
        check("rst_sel", sel, 0);
        check("rst_dout", dout, 0);
        check("rst_dout_src", dout_src, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_done", done, 0);
        check("rst_collide", collide, 0);
        rst_n = 1'b1;
        tick(3);
        check("idle_done", done, 0);
        check("idle_sel", sel, 0);

        // basic drain {3,0,2,0}
        expect_w(0, 0); expect_w(0, 1); expect_w(0, 2); expect_w(2, 0); expect_w(2, 1);
        start_crossing(3, 0, 2, 0);
        wait_done(40, "t1_done");
        check("t1_collide", collide, 0);
        check("t1_sb_empty", q.size(), 0);

        // stall 10 cycles with 5 items on source 1
        for (int j = 0; j < 5; j++) expect_w(1, j);
        start_crossing(0, 5, 0, 0);
        tick(2);
        stall = 1'b1;
        tick(10);
        check("t2_hold_valid", dout_valid, 1);
        check("t2_hold_src", dout_src, 1);
        check("t2_hold_dat", dout, mk_word(1, 0));
        stall = 1'b0;
        wait_done(40, "t2_done");
        check("t2_sb_empty", q.size(), 0);

        // sticky grant: source 2 streaming, source 0 rises mid-stream
        for (int j = 0; j < 6; j++) expect_w(2, j);
        for (int j = 0; j < 3; j++) expect_w(0, j);
        start_crossing(0, 0, 6, 0);
        tick(2);
        check("t3_sel_first", sel, 4'b0100);
        ld_mask = 4'b0001; ld_cnt[0] = 3; ld = 1'b1;
        tick(1);
        ld = 1'b0;
        k = 0;
        while (has_dat[2] === 1'b1 && k < 20) begin
            check("t3_sticky", sel, 4'b0100);
            tick(1);
            k++;
        end
        check("t3_src2_drained", has_dat[2], 0);
        tick(1);
        check("t3_sel_src0", sel, 4'b0001);
        wait_done(40, "t3_done");
        check("t3_sb_empty", q.size(), 0);

        // collision during the setup window
        ld_cnt[0] = 0; ld_cnt[1] = 0; ld_cnt[2] = 0; ld_cnt[3] = 0;
        ld_mask = 4'b1111; ld = 1'b1; init = 1'b1; setup = 1'b1;
        tick(1);
        ld = 1'b0; init = 1'b0;
        check("t4_collide_clear", collide, 0);
        dat_force[1] = mk_word(1, 7);
        dat_force[2] = mk_word(2, 7);
        mv_force = 4'b0110;
        expect_w(1, 7);
        tick(1);
        mv_force = 4'b0000;
        check("t4_collide_set", collide, 1);
        tick(3);
        check("t4_sb_empty", q.size(), 0);
        check("t4_collide_held", collide, 1);
        setup = 1'b0;
        wait_done(10, "t4_done");
        check("t4_collide_in_done", collide, 1);
        init = 1'b1; setup = 1'b1;
        tick(1);
        init = 1'b0;
        check("t4_collide_init", collide, 0);
        check("t4_done_init", done, 0);
        setup = 1'b0;

        // empty crossing: done within 4 cycles of setup falling
        start_crossing(0, 0, 0, 0);
        k = 0;
        while (done !== 1'b1 && k < 4) begin
            tick(1);
            k++;
        end
        check("t5_done", done, 1);
        check("t5_no_valid", dout_valid, 0);

        // reset with 3 words queued
        start_crossing(0, 0, 0, 3);
        stall = 1'b1;
        tick(8);
        check("t6_queued", dout_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", dout_valid, 0);
        check("t6_rst_sel", sel, 0);
        check("t6_rst_dout", dout, 0);
        check("t6_rst_src", dout_src, 0);
        tick(1);
        rst_n = 1'b1;
        stall = 1'b0;
        tick(8);
        check("t6_idle_valid", dout_valid, 0);
        check("t6_idle_done", done, 0);

        // init with 3 words queued
        start_crossing(0, 0, 0, 3);
        stall = 1'b1;
        tick(8);
        check("t7_queued", dout_valid, 1);
        ld_cnt[3] = 0; ld_mask = 4'b1111; ld = 1'b1; init = 1'b1; setup = 1'b1;
        tick(1);
        ld = 1'b0; init = 1'b0;
        check("t7_init_valid", dout_valid, 0);
        check("t7_init_sel", sel, 0);
        check("t7_init_done", done, 0);
        stall = 1'b0;
        setup = 1'b0;
        wait_done(20, "t7_done");
        check("t7_no_valid", dout_valid, 0);

        tick(2);
        check("final_sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prio_encoder_mt.md
PRIO_ENCODER_MT -- requirements
Module: prio_encoder_MT

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of prio_support_MT readers arbitrated.
REQ-002 SHALL have parameter DATA_W, default 36, memory word width.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port init  input  1  start-of-crossing pulse, same one sent to the readers.
REQ-006 SHALL have port setup  input  1  multi-cycle setup window, same one sent to the readers.
REQ-007 SHALL have port has_dat  input  N_SRC  per-reader "items remain" flags.
REQ-008 SHALL have port mem_valid  input  N_SRC  per-reader valid, aligned with mem_dat.
REQ-009 SHALL have port mem_dat  input  N_SRC*DATA_W  per-reader memory words; source i at bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port stall  input  1  downstream not accepting this cycle.
REQ-011 SHALL have port sel  output  N_SRC  registered one-hot reader select; all-zero is allowed.
REQ-012 SHALL have port dout  output  DATA_W  merged output word.
REQ-013 SHALL have port dout_src  output  clog2(N_SRC)  index of the source of dout.
REQ-014 SHALL have port dout_valid  output  1  dout/dout_src valid and accepted when stall=0.
REQ-015 SHALL have port done  output  1  all items for the crossing delivered; held until next init.
REQ-016 SHALL have port collide  output  1  sticky flag: more than one mem_valid in the same cycle.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ARB, FLUSH, DONE.
REQ-018 SHALL go from any state to SETUP on init=1; init has priority over all other events.
REQ-019 SHALL stay in SETUP while setup=1, go to ARB on the first cycle with setup=0, and drive sel=0 throughout SETUP.
REQ-020 In ARB, SHALL register sel as one-hot of the lowest-index has_dat bit, but keep the current sel while its has_dat bit stays 1 (sticky grant, no preemption).
REQ-021 SHALL force sel=0 in ARB when skid FIFO occupancy >= DEPTH-2, covering the 2-cycle sel-to-mem_valid latency.
REQ-022 SHALL include a 4-entry skid FIFO (DEPTH=4) storing {source index, word}, written on any mem_valid bit.
REQ-023 On multiple mem_valid bits in one cycle, SHALL write only the lowest index and set collide until next init or reset.
REQ-024 SHALL present the FIFO head on dout/dout_src, with dout_valid=1 when FIFO is non-empty, and pop when dout_valid=1 and stall=0.
REQ-025 SHALL allow simultaneous push and pop on a non-empty FIFO, leaving occupancy unchanged.
REQ-026 SHALL drop a push to a full FIFO and assert no other side effect; this is unreachable when REQ-021 holds.
REQ-027 SHALL go from ARB to FLUSH when has_dat=0 and sel=0 in the same cycle.
REQ-028 SHALL return from FLUSH to ARB if any has_dat rises.
REQ-029 SHALL go from FLUSH to DONE once 2 cycles pass with no mem_valid and the FIFO is empty.
REQ-030 SHALL assert done only in DONE, and hold DONE until init.
REQ-031 On init, SHALL clear the FIFO (in-flight words discarded), collide, done and sel.
REQ-032 SHALL have a fixed latency of 1 cycle from mem_valid to dout_valid when the FIFO is empty and stall=0.

Reset
REQ-033 On rst_n=0, SHALL asynchronously drive state=IDLE, sel=0, dout=0, dout_src=0, dout_valid=0, done=0, collide=0, and FIFO occupancy=0.
REQ-034 SHALL remain in IDLE after reset release until init; reset mid-crossing discards all data.

Verification
REQ-035 Basic drain: with reader counts {3,0,2,0} and stall=0, the bench SHALL see dout_src sequence 0,0,0,2,2, done asserted, and collide=0.
REQ-036 Stall: with 5 items on source 1 and stall held high 10 cycles mid-run, the bench SHALL see occupancy never above 4, no word lost, and 5 words delivered in order.
REQ-037 Sticky grant: with has_dat[2] active and has_dat[0] rising mid-stream, the bench SHALL see sel stay 4'b0100 until has_dat[2] falls, then sel=4'b0001.
REQ-038 Collision: mem_valid=4'b0110 forced once, the bench SHALL see the source-1 word written, source 2 dropped, and collide=1 held until init.
REQ-039 Empty crossing: with all counts 0, after setup falls the bench SHALL see done within 4 cycles and dout_valid never asserted.
REQ-040 Reset/init mid-operation: rst_n or init pulsed with 3 words queued, the bench SHALL see outputs clear immediately (reset) or next cycle (init), and no stale words emitted.
